sdio_spi_bridge_cd: RTL

Parametrised successor SD-card SPI-mode bridge between the quad-SPI controller and the SDIO pins. Adds:
- configurable MISO synchroniser depth;
- card-detect / write-protect synchronisation with debounce;
- a power-up sequencer that issues the SD-mandated ≥74 idle clocks, with CS and CMD high, before the SPI controller gets the card.

Sits in the board shell between the SPI controller and the SD-socket IOBUFs.

---
 rtl/sdio_bridge_pkg.sv | 24 ++
 rtl/sdio_sync_bit.sv | 31 +++
 rtl/sdio_spi_bridge_cd.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/sdio_bridge_pkg.sv
// Shared definitions for the SD-card SPI-mode bridge.
//   bridge_state_e   : card lifecycle state (no card, debounce, power-up clocks, ready)
//   SD_MIN_INIT_CLKS : minimum idle sd_sck rising edges an SD card needs at power-up
//   cnt_w()          : width of a counter that must hold the value n
package sdio_bridge_pkg;

  typedef enum logic [1:0] {
    NO_CARD  = 2'd0,
    DEBOUNCE = 2'd1,
    INIT     = 2'd2,
    READY    = 2'd3
  } bridge_state_e;

  localparam int SD_MIN_INIT_CLKS = 74;
  localparam int SYNC_MIN         = 1;
  localparam int SYNC_MAX         = 4;
  localparam int DEBOUNCE_MIN     = 2;
  localparam int CLK_DIV_MIN      = 1;

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sdio_sync_bit.sv
// Single-bit multi-flop synchroniser with synchronous active-high reset.
//   clk_i   : destination clock
//   reset_i : synchronous reset, clears every stage to 0
//   d_i     : asynchronous input
//   q_o     : synchronised output, STAGES clk cycles after d_i
module sdio_sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  if (STAGES == 1) begin : g_one
    always_ff @(posedge clk_i) begin
      if (reset_i) sync_q <= '0;
      else         sync_q <= d_i;
    end
  end else begin : g_chain
    always_ff @(posedge clk_i) begin
      if (reset_i) sync_q <= '0;
      else         sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/sdio_spi_bridge_cd.sv
// SD-card SPI-mode bridge between the quad-SPI controller and the SD socket,
// with card-detect debounce and a power-up sequencer that issues idle clocks
// (CS and CMD high) before handing the card to the controller.
//   clk, reset              : system clock, synchronous active-high reset
//   sd_cmd / sd_dat_3       : MOSI / CS to the card, tristated with no card
//   sd_dat_0                : MISO from the card (never driven here)
//   sd_dat_1, sd_dat_2      : unused, always tristated
//   sd_sck                  : card clock (init divider or controller SCK)
//   sd_cd, sd_wp            : asynchronous socket card-detect / write-protect
//   spi_sck, spi_dq_o, spi_cs : controller side (bit0 of spi_dq_o = MOSI)
//   spi_dq_i                : controller data in, bit1 = MISO, others 0
//   card_present, card_wp, init_done, cd_irq : status to software
module sdio_spi_bridge_cd
  import sdio_bridge_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 65536,
  parameter int INIT_CLKS       = 80,
  parameter int CLK_DIV         = 250,
  parameter bit CD_ACTIVE_LOW   = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  inout  wire        sd_cmd,
  inout  wire        sd_dat_0,
  inout  wire        sd_dat_1,
  inout  wire        sd_dat_2,
  inout  wire        sd_dat_3,
  output logic       sd_sck,
  input  logic       sd_cd,
  input  logic       sd_wp,
  input  logic       spi_sck,
  input  logic [3:0] spi_dq_o,
  output logic [3:0] spi_dq_i,
  input  logic       spi_cs,
  output logic       card_present,
  output logic       card_wp,
  output logic       init_done,
  output logic       cd_irq
);

  // Out-of-range parameters are clamped to the nearest legal value.
  localparam int SYNC_N = (SYNC_STAGES < SYNC_MIN) ? SYNC_MIN :
                          (SYNC_STAGES > SYNC_MAX) ? SYNC_MAX : SYNC_STAGES;
  localparam int DEB_N  = (DEBOUNCE_CYCLES < DEBOUNCE_MIN) ? DEBOUNCE_MIN : DEBOUNCE_CYCLES;
  localparam int INIT_N = (INIT_CLKS < SD_MIN_INIT_CLKS) ? SD_MIN_INIT_CLKS : INIT_CLKS;
  localparam int DIV_N  = (CLK_DIV < CLK_DIV_MIN) ? CLK_DIV_MIN : CLK_DIV;

  localparam int DEB_W  = cnt_w(DEB_N);
  localparam int EDGE_W = cnt_w(INIT_N);
  localparam int DIV_W  = cnt_w(DIV_N);

  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_N - 1);
  localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(INIT_N);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV_N - 1);

  logic cd_raw, cd_s, wp_s, miso_s;

  // Normalise polarity before synchronising so reset (0) means "no card".
  assign cd_raw = CD_ACTIVE_LOW ? ~sd_cd : sd_cd;

  sdio_sync_bit #(.STAGES(SYNC_N)) u_sync_cd (
    .clk_i(clk), .reset_i(reset), .d_i(cd_raw), .q_o(cd_s)
  );
  sdio_sync_bit #(.STAGES(SYNC_N)) u_sync_wp (
    .clk_i(clk), .reset_i(reset), .d_i(sd_wp), .q_o(wp_s)
  );
  sdio_sync_bit #(.STAGES(SYNC_N)) u_sync_miso (
    .clk_i(clk), .reset_i(reset), .d_i(sd_dat_0), .q_o(miso_s)
  );

  bridge_state_e     state_q, state_d;
  logic [DEB_W-1:0]  deb_q, deb_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [EDGE_W-1:0] edge_q, edge_d;
  logic              sck_q, sck_d;
  logic              present_q, present_d;
  logic              irq_q, irq_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= NO_CARD;
      deb_q     <= '0;
      div_q     <= '0;
      edge_q    <= '0;
      sck_q     <= 1'b0;
      present_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      deb_q     <= deb_d;
      div_q     <= div_d;
      edge_q    <= edge_d;
      sck_q     <= sck_d;
      present_q <= present_d;
      irq_q     <= irq_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    deb_d     = deb_q;
    div_d     = div_q;
    edge_d    = edge_q;
    sck_d     = sck_q;
    present_d = present_q;
    unique case (state_q)
      NO_CARD: begin
        deb_d     = '0;
        div_d     = '0;
        edge_d    = '0;
        sck_d     = 1'b0;
        present_d = 1'b0;
        if (cd_s) state_d = DEBOUNCE;
      end
      DEBOUNCE: begin
        // The entry cycle counts as the first stable sample, so acceptance
        // happens when the incremented count reaches DEB_N-1.
        if (cd_s) begin
          deb_d = deb_q + 1'b1;
          if (deb_d == DEB_LAST) begin
            state_d   = INIT;
            present_d = 1'b1;
          end
        end
      end
      INIT: begin
        if (edge_q == EDGE_LAST && !sck_q) begin
          state_d = READY;
        end else if (div_q == DIV_LAST) begin
          div_d = '0;
          sck_d = ~sck_q;
          if (!sck_q) edge_d = edge_q + 1'b1;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      READY: begin
      end
      default: state_d = NO_CARD;
    endcase

    // Removal is not debounced: any loss of card-detect aborts immediately.
    if (state_q != NO_CARD && !cd_s) begin
      state_d   = NO_CARD;
      deb_d     = '0;
      div_d     = '0;
      edge_d    = '0;
      sck_d     = 1'b0;
      present_d = 1'b0;
    end

    irq_d = present_d ^ present_q;
  end

  logic drive, sck_c, cmd_c, cs_c, miso_c;

  always_comb begin
    drive  = 1'b0;
    sck_c  = 1'b0;
    cmd_c  = 1'b1;
    cs_c   = 1'b1;
    miso_c = 1'b1;
    unique case (state_q)
      INIT: begin
        drive = 1'b1;
        sck_c = sck_q;
      end
      READY: begin
        drive  = 1'b1;
        sck_c  = spi_sck;
        cmd_c  = spi_dq_o[0];
        cs_c   = spi_cs;
        miso_c = miso_s;
      end
      default: begin
      end
    endcase
  end

  // Inline IO buffers: pins float whenever the card must not be back-powered.
  assign sd_cmd   = drive ? cmd_c : 1'bz;
  assign sd_dat_3 = drive ? cs_c  : 1'bz;
  assign sd_dat_0 = 1'bz;
  assign sd_dat_1 = 1'bz;
  assign sd_dat_2 = 1'bz;

  assign sd_sck       = sck_c;
  assign spi_dq_i     = {2'b00, miso_c, 1'b0};
  assign card_present = present_q;
  assign card_wp      = wp_s & present_q;
  assign init_done    = (state_q == READY);
  assign cd_irq       = irq_q;

  logic unused_pins;
  assign unused_pins = ^{spi_dq_o[3:1], sd_dat_1, sd_dat_2};

endmodule
